// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port: request/address from the fetch unit,
// ready/data back from memory.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over a req/ready handshake
// and presents each instruction with its PC+1 to IF/ID, honouring stalls and redirects.
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 12,
    parameter int                INSTR_W  = 19,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [ADDR_W-1:0]          branch_target,
    instruction_fetch_unit_if.master   imem,
    output logic                       if_valid,
    output logic [INSTR_W-1:0]         if_instruction,
    output logic [ADDR_W-1:0]          if_pc_plus1
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next;
    logic [ADDR_W-1:0]  pending_pc, pending_pc_next;
    logic [INSTR_W-1:0] hold_instr, hold_instr_next;
    logic [ADDR_W-1:0]  hold_pc_plus1, hold_pc_plus1_next;
    logic [ADDR_W-1:0]  pc_plus1;

    logic               req_c;
    logic               valid_c;
    logic [INSTR_W-1:0] instr_c;
    logic [ADDR_W-1:0]  pc_plus1_c;

    assign pc_plus1 = pc + PC_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            pending_pc    <= '0;
            hold_instr    <= '0;
            hold_pc_plus1 <= '0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            pending_pc    <= pending_pc_next;
            hold_instr    <= hold_instr_next;
            hold_pc_plus1 <= hold_pc_plus1_next;
        end
    end

    // Redirects beat stalls; pc only moves when the current read completes,
    // so imem_addr is stable for the whole outstanding request.
    always_comb begin
        state_next         = state;
        pc_next            = pc;
        pending_pc_next    = pending_pc;
        hold_instr_next    = hold_instr;
        hold_pc_plus1_next = hold_pc_plus1;
        req_c              = 1'b0;
        valid_c            = 1'b0;
        instr_c            = '0;
        pc_plus1_c         = '0;

        unique case (state)
            FETCH: begin
                req_c      = 1'b1;
                valid_c    = imem.imem_ready;
                instr_c    = imem.imem_rdata;
                pc_plus1_c = pc_plus1;
                if (branch_taken) begin
                    valid_c = 1'b0;
                    if (imem.imem_ready) begin
                        pc_next = branch_target;
                    end else begin
                        pending_pc_next = branch_target;
                        state_next      = DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    pc_next = pc_plus1;
                    if (stall) begin
                        hold_instr_next    = imem.imem_rdata;
                        hold_pc_plus1_next = pc_plus1;
                        state_next         = HOLD;
                    end
                end
            end

            HOLD: begin
                valid_c    = 1'b1;
                instr_c    = hold_instr;
                pc_plus1_c = hold_pc_plus1;
                if (branch_taken) begin
                    valid_c    = 1'b0;
                    pc_next    = branch_target;
                    state_next = FETCH;
                end else if (!stall) begin
                    state_next = FETCH;
                end
            end

            DRAIN: begin
                req_c = 1'b1;
                if (branch_taken) begin
                    pending_pc_next = branch_target;
                end
                if (imem.imem_ready) begin
                    pc_next    = branch_taken ? branch_target : pending_pc;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase

        // Memory data flows straight through combinationally, so gate it during reset.
        if (rst) begin
            req_c      = 1'b0;
            valid_c    = 1'b0;
            instr_c    = '0;
            pc_plus1_c = '0;
        end
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = rst ? '0 : pc;
    assign if_valid       = valid_c;
    assign if_instruction = instr_c;
    assign if_pc_plus1    = pc_plus1_c;

endmodule
